serial_adder_seq: RTL and testbench
===================================

// Module: serial_adder_seq
// PURPOSE
//  Bit-serial, LSB-first adder/subtractor for WIDTH-bit two's-complement operands.
//  Consumes one bit of A and one bit of B per clock and emits one registered sum bit per clock.
//  Flags carry_out and signed overflow at the end of each word.
//  Parametrised successor of the single-bit adder cell; sized for 8-in/8-out pad wrappers.
// PARAMETERS
//  WIDTH   8  operand/result word length in bits (>=1)
//  SUB_EN  1  1: mode port selects A-B; 0: mode ignored, always A+B
// PORTS
//  clk        in   1  single clock, rising edge
//  reset      in   1  asynchronous, active-low; clears all state
//  start      in   1  word start; bit 0 of a_bit/b_bit presented in the same cycle
//  mode       in   1  0=add, 1=subtract (A-B); sampled only on the accepted start cycle
//  a_bit      in   1  serial operand A, LSB first
//  b_bit      in   1  serial operand B, LSB first
//  busy       out  1  high while bits 1..WIDTH-1 of a word are being consumed
//  s_bit      out  1  registered sum bit
//  s_valid    out  1  s_bit carries a valid bit this cycle
//  done       out  1  one-cycle pulse coincident with the last s_valid of a word
//  carry_out  out  1  final carry (subtract: 1 = no borrow); valid when done=1
//  overflow   out  1  signed overflow (carry into MSB XOR carry out); valid when done=1
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE; cnt, carry and mode_q cleared.
//    busy, s_bit, s_valid, done, carry_out and overflow all read 0.
//  - States: IDLE, RUN.
//  - Consume cycle = (IDLE & start) | RUN. Each consume cycle computes:
//      b' = b_bit ^ mode_eff
//      {c,s} = a_bit + b' + cin
//    cin = mode_eff on the start cycle, otherwise the carry register.
//    mode_eff = mode on the start cycle, mode_q afterwards; forced 0 when SUB_EN=0.
//  - Latency: the sum bit for input bit k appears on s_bit with s_valid=1 in the cycle after it is consumed.
//    A word occupies WIDTH consecutive s_valid cycles; no gaps are permitted or produced.
//  - IDLE & start: consume bit 0, latch mode_q, cnt<=1.
//    Next state is RUN if WIDTH>1, else stay IDLE (last bit).
//  - RUN: consume a bit each cycle; start is ignored. When cnt==WIDTH-1, go to IDLE and cnt<=0.
//  - On the last-bit consume cycle, register done=1 together with carry_out=c and overflow=cin^c
//    (cin here is the carry into the MSB). carry_out/overflow hold until the next done; done itself is a single pulse.
//  - Back-to-back: start in the cycle where done=1 (state IDLE) is accepted.
//    This gives a continuous s_valid stream with no bubble.
//  - start while busy=1: ignored, no error flag.
//  - Reset asserted mid-word: the partial word is discarded and no done pulse is produced.
//  - cnt width = $clog2(WIDTH), minimum 1 bit; cnt never exceeds WIDTH-1.
//  - a_bit/b_bit are don't-care in IDLE without start.
// STRUCTURE
//  - config.vh: ST_IDLE/ST_RUN encodings; MODE_ADD/MODE_SUB constants.
//  - config.vh: SERIAL_WIDTH default; pad bit-ID macros for the wrapper mapping.
//  - Sub-module: fulladder (1-bit combinational: a, b, cin -> s, cout), instantiated once for the datapath.
//  - Separate pad wrapper top_serial_adder maps io_in/io_out to these ports.
// TESTING (WIDTH=4, SUB_EN=1 unless noted; operands listed MSB..LSB, fed LSB first)
//  1 add 1011+0110: s_bit stream 1,0,0,0 (=0001); done with carry_out=1, overflow=0; busy high 3 cycles.
//  2 add 0111+0001: s=1000; carry_out=0, overflow=1.
//  3 sub 0101-0110: s=1111; carry_out=0 (borrow), overflow=0.
//    sub 1000-0001: s=0111; carry_out=1, overflow=1.
//  4 Back-to-back: start asserted on the done cycle -> 8 contiguous s_valid cycles, two done pulses 4 cycles apart.
//    A start pulse mid-word is ignored.
//  5 reset=0 after 2 bits consumed: all outputs 0 immediately.
//    After release, a new word (add 0001+0001) gives s=0010, carry_out=0, with no stale done.
//  6 WIDTH=1: start with a=1, b=1, add -> next cycle s_bit=0, s_valid=1, done=1, carry_out=1, overflow=1; busy stays 0.
//    SUB_EN=0 with mode=1 -> adds.

Source files
------------

// File: rtl/serial_adder_seq_pkg.sv
// rtl/serial_adder_seq_pkg.sv - shared encodings and sizing helpers for the serial adder
package serial_adder_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int SERIAL_WIDTH = 8;

    // A one-bit word still needs a one-bit counter register.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_seq_fulladder.sv
// rtl/serial_adder_seq_fulladder.sv - one-bit combinational full adder cell
module serial_adder_seq_fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_seq.sv
// rtl/serial_adder_seq.sv - bit-serial LSB-first adder/subtractor with registered outputs
module serial_adder_seq
    import serial_adder_seq_pkg::*;
#(
    parameter int WIDTH  = SERIAL_WIDTH,
    parameter bit SUB_EN = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic mode,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic s_bit,
    output logic s_valid,
    output logic done,
    output logic carry_out,
    output logic overflow
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          mode_q;

    logic consume;
    logic last_bit;
    logic mode_eff;
    logic cin;
    logic b_eff;
    logic sum;
    logic cout;

    assign consume  = ((state == ST_IDLE) && start) || (state == ST_RUN);
    assign mode_eff = SUB_EN ? ((state == ST_IDLE) ? mode : mode_q) : MODE_ADD;
    // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
    assign cin      = (state == ST_IDLE) ? mode_eff : carry;
    assign b_eff    = b_bit ^ (mode_eff == MODE_SUB);
    assign last_bit = (state == ST_IDLE) ? (WIDTH == 1) : (cnt == CNT_LAST);

    serial_adder_seq_fulladder u_fa (
        .a    (a_bit),
        .b    (b_eff),
        .cin  (cin),
        .s    (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            mode_q    <= 1'b0;
            busy      <= 1'b0;
            s_bit     <= 1'b0;
            s_valid   <= 1'b0;
            done      <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            s_valid <= consume;
            s_bit   <= consume & sum;
            done    <= consume & last_bit;
            if (consume) begin
                carry <= cout;
                if (last_bit) begin
                    carry_out <= cout;
                    overflow  <= cin ^ cout;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        if (WIDTH > 1) begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb/tb_serial_adder_seq.sv - self-checking bench for serial_adder_seq
module tb_serial_adder_seq;

    localparam int W    = 4;
    localparam int MAXC = 256;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic a_bit = 1'b0;
    logic b_bit = 1'b0;

    logic busy4, s4, sv4, done4, co4, ov4;
    logic busyn, sn, svn, donen, con, ovn;
    logic busy1, s1, sv1, done1, co1, ov1;

    int total = 0;
    int bad   = 0;

    logic d_st[MAXC], d_md[MAXC], d_a[MAXC], d_b[MAXC];
    logic o_sv[MAXC], o_s[MAXC], o_dn[MAXC], o_co[MAXC], o_ov[MAXC], o_bz[MAXC];
    logic n_sv[MAXC], n_s[MAXC], n_dn[MAXC], n_co[MAXC], n_ov[MAXC];

    always #5 clk = ~clk;

    serial_adder_seq #(.WIDTH(W), .SUB_EN(1'b1)) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .a_bit(a_bit), .b_bit(b_bit),
        .busy(busy4), .s_bit(s4), .s_valid(sv4), .done(done4), .carry_out(co4), .overflow(ov4)
    );

    serial_adder_seq #(.WIDTH(W), .SUB_EN(1'b0)) u_dutn (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .a_bit(a_bit), .b_bit(b_bit),
        .busy(busyn), .s_bit(sn), .s_valid(svn), .done(donen), .carry_out(con), .overflow(ovn)
    );

    serial_adder_seq #(.WIDTH(1), .SUB_EN(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .a_bit(a_bit), .b_bit(b_bit),
        .busy(busy1), .s_bit(s1), .s_valid(sv1), .done(done1), .carry_out(co1), .overflow(ov1)
    );

    // Reference: true integer arithmetic on w-bit words, signed range test for overflow.
    function automatic void ref_word(input int w, input int a, input int b, input bit m,
                                     output int s, output bit c, output bit v);
        int mask, bb, tot, sa, sb, t;
        mask = (1 << w) - 1;
        bb   = m ? ((~b) & mask) : b;
        tot  = a + bb + int'(m);
        s    = tot & mask;
        c    = ((tot >> w) & 1) != 0;
        sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        t    = m ? sa - sb : sa + sb;
        v    = (t > (1 << (w - 1)) - 1) || (t < -(1 << (w - 1)));
    endfunction

    task automatic clear_sched(input int n);
        for (int i = 0; i < n; i++) begin
            d_st[i] = 1'b0;
            d_md[i] = 1'($urandom);
            d_a[i]  = 1'($urandom);
            d_b[i]  = 1'($urandom);
        end
    endtask

    task automatic place_word(input int at, input logic [3:0] a, input logic [3:0] b, input logic m);
        d_st[at] = 1'b1;
        d_md[at] = m;
        for (int i = 0; i < W; i++) begin
            d_a[at + i] = a[i];
            d_b[at + i] = b[i];
        end
    endtask

    // obs[k] holds the outputs following the rising edge that consumed schedule entry k.
    task automatic run_sched(input int n);
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            if (k > 0) begin
                o_sv[k-1] = sv4; o_s[k-1] = s4; o_dn[k-1] = done4;
                o_co[k-1] = co4; o_ov[k-1] = ov4; o_bz[k-1] = busy4;
                n_sv[k-1] = svn; n_s[k-1] = sn; n_dn[k-1] = donen;
                n_co[k-1] = con; n_ov[k-1] = ovn;
            end
            if (k < n) begin
                start = d_st[k]; mode = d_md[k]; a_bit = d_a[k]; b_bit = d_b[k];
            end else begin
                start = 1'b0; mode = 1'($urandom); a_bit = 1'($urandom); b_bit = 1'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy4, s4, sv4, done4, co4, ov4} !== 6'b0) begin
            bad++; $display("FAIL reset_w4 got=%b want=000000", {busy4, s4, sv4, done4, co4, ov4});
        end
        total++;
        if ({busy1, s1, sv1, done1, co1, ov1, busyn, sn, svn, donen, con, ovn} !== 12'b0) begin
            bad++; $display("FAIL reset_other got=%b want=0", {busy1, s1, sv1, done1, co1, ov1, busyn, sn, svn, donen, con, ovn});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [3:0] ta[4] = '{4'b1011, 4'b0111, 4'b0101, 4'b1000};
        logic [3:0] tb[4] = '{4'b0110, 4'b0001, 4'b0110, 4'b0001};
        logic       tm[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] ts[4] = '{4'b0001, 4'b1000, 4'b1111, 4'b0111};
        logic       tc[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       tv[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int t = 0; t < 4; t++) begin
            logic [3:0] got;
            int nb, nd;
            bit vok;
            clear_sched(8);
            place_word(0, ta[t], tb[t], tm[t]);
            run_sched(6);
            vok = 1; nb = 0; nd = 0; got = '0;
            for (int i = 0; i < W; i++) begin
                got[i] = o_s[i];
                if (o_sv[i] !== 1'b1) vok = 0;
            end
            if (o_sv[W] !== 1'b0) vok = 0;
            for (int i = 0; i < 6; i++) begin
                if (o_bz[i] === 1'b1) nb++;
                if (o_dn[i] === 1'b1) nd++;
            end
            total++;
            if (got !== ts[t]) begin bad++; $display("FAIL dir%0d_sum got=%b want=%b", t, got, ts[t]); end
            total++;
            if (!vok) begin bad++; $display("FAIL dir%0d_valid got=gap want=4 contiguous", t); end
            total++;
            if (o_dn[W-1] !== 1'b1 || nd != 1) begin bad++; $display("FAIL dir%0d_done got=%0d pulses want=1 at bit3", t, nd); end
            total++;
            if (o_co[W-1] !== tc[t]) begin bad++; $display("FAIL dir%0d_carry got=%b want=%b", t, o_co[W-1], tc[t]); end
            total++;
            if (o_ov[W-1] !== tv[t]) begin bad++; $display("FAIL dir%0d_ovf got=%b want=%b", t, o_ov[W-1], tv[t]); end
            total++;
            if (nb != 3) begin bad++; $display("FAIL dir%0d_busy got=%0d want=3", t, nb); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a0 = 4'b0011, b0 = 4'b0101, a1 = 4'b1100, b1 = 4'b0110;
        logic [3:0] g0, g1;
        int es0, es1, nd, nv;
        bit ec0, ev0, ec1, ev1;
        clear_sched(12);
        place_word(0, a0, b0, 1'b0);
        place_word(W, a1, b1, 1'b1);
        d_st[2] = 1'b1;
        run_sched(10);
        ref_word(W, int'(a0), int'(b0), 1'b0, es0, ec0, ev0);
        ref_word(W, int'(a1), int'(b1), 1'b1, es1, ec1, ev1);
        nd = 0; nv = 0;
        for (int i = 0; i < W; i++) begin g0[i] = o_s[i]; g1[i] = o_s[W + i]; end
        for (int i = 0; i < 10; i++) begin
            if (o_sv[i] === 1'b1) nv++;
            if (o_dn[i] === 1'b1) nd++;
        end
        total++;
        if (nv != 8 || o_sv[2*W-1] !== 1'b1 || o_sv[2*W] !== 1'b0) begin
            bad++; $display("FAIL b2b_valid got=%0d want=8 contiguous", nv);
        end
        total++;
        if (nd != 2 || o_dn[W-1] !== 1'b1 || o_dn[2*W-1] !== 1'b1) begin
            bad++; $display("FAIL b2b_done got=%0d pulses want=2 at 3,7", nd);
        end
        total++;
        if (int'(g0) != es0 || int'(g1) != es1) begin
            bad++; $display("FAIL b2b_sum got=%b,%b want=%0d,%0d", g0, g1, es0, es1);
        end
        total++;
        if (o_co[2*W-1] !== ec1 || o_ov[2*W-1] !== ev1 || o_co[W-1] !== ec0 || o_ov[W-1] !== ev0) begin
            bad++; $display("FAIL b2b_flags got=%b%b,%b%b want=%b%b,%b%b",
                            o_co[W-1], o_ov[W-1], o_co[2*W-1], o_ov[2*W-1], ec0, ev0, ec1, ev1);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] got;
        int nd;
        clear_sched(4);
        place_word(0, 4'b0011, 4'b0101, 1'b0);
        run_sched(2);
        reset = 1'b0;
        #1;
        total++;
        if ({busy4, s4, sv4, done4, co4, ov4} !== 6'b0) begin
            bad++; $display("FAIL midreset_out got=%b want=000000", {busy4, s4, sv4, done4, co4, ov4});
        end
        @(negedge clk);
        reset = 1'b1;
        clear_sched(10);
        place_word(1, 4'b0001, 4'b0001, 1'b0);
        run_sched(8);
        nd = 0; got = '0;
        for (int i = 0; i < W; i++) got[i] = o_s[1 + i];
        for (int i = 0; i < 8; i++) if (o_dn[i] === 1'b1) nd++;
        total++;
        if (o_dn[0] !== 1'b0 || o_sv[0] !== 1'b0) begin
            bad++; $display("FAIL midreset_stale got=done%b valid%b want=0,0", o_dn[0], o_sv[0]);
        end
        total++;
        if (got !== 4'b0010) begin bad++; $display("FAIL midreset_sum got=%b want=0010", got); end
        total++;
        if (nd != 1 || o_dn[W] !== 1'b1 || o_co[W] !== 1'b0) begin
            bad++; $display("FAIL midreset_done got=%0d pulses carry=%b want=1,0", nd, o_co[W]);
        end
    endtask

    task automatic test_width1();
        int es;
        bit ec, ev, pa, pb, pm;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; a_bit = 1'b1; b_bit = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if ({s1, sv1, done1, co1, ov1, busy1} !== 6'b011110) begin
            bad++; $display("FAIL w1_basic got=%b want=011110", {s1, sv1, done1, co1, ov1, busy1});
        end
        @(negedge clk);
        total++;
        if (done1 !== 1'b0 || sv1 !== 1'b0 || co1 !== 1'b1 || ov1 !== 1'b1) begin
            bad++; $display("FAIL w1_hold got=done%b valid%b c%b v%b want=0,0,1,1", done1, sv1, co1, ov1);
        end
        pa = 0; pb = 0; pm = 0;
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                ref_word(1, int'(pa), int'(pb), pm, es, ec, ev);
                total++;
                if (s1 !== es[0] || sv1 !== 1'b1 || done1 !== 1'b1 || co1 !== ec || ov1 !== ev || busy1 !== 1'b0) begin
                    bad++; $display("FAIL w1_stream%0d got=s%b c%b v%b want=s%b c%b v%b", i, s1, co1, ov1, es[0], ec, ev);
                end
            end
            if (i < 16) begin
                pa = 1'($urandom); pb = 1'($urandom); pm = 1'($urandom);
                start = 1'b1; mode = pm; a_bit = pa; b_bit = pb;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_sub_en0();
        logic [3:0] g4, gn;
        clear_sched(8);
        place_word(0, 4'b0110, 4'b0011, 1'b1);
        run_sched(6);
        for (int i = 0; i < W; i++) begin g4[i] = o_s[i]; gn[i] = n_s[i]; end
        total++;
        if (gn !== 4'b1001 || n_co[W-1] !== 1'b0 || n_ov[W-1] !== 1'b1 || n_dn[W-1] !== 1'b1) begin
            bad++; $display("FAIL suben0_add got=%b c%b v%b want=1001 c0 v1", gn, n_co[W-1], n_ov[W-1]);
        end
        total++;
        if (g4 !== 4'b0011 || o_co[W-1] !== 1'b1 || o_ov[W-1] !== 1'b0) begin
            bad++; $display("FAIL suben1_sub got=%b c%b v%b want=0011 c1 v0", g4, o_co[W-1], o_ov[W-1]);
        end
    endtask

    task automatic test_random();
        int starts[32];
        logic [3:0] wa[32], wb[32];
        logic wm[32];
        bit inword[MAXC];
        int pos, nw, nv, nd, errs, errn;
        nw = 30; pos = 0; errs = 0; errn = 0;
        clear_sched(MAXC);
        for (int i = 0; i < MAXC; i++) inword[i] = 0;
        for (int w = 0; w < nw; w++) begin
            wa[w] = 4'($urandom); wb[w] = 4'($urandom); wm[w] = 1'($urandom);
            starts[w] = pos;
            place_word(pos, wa[w], wb[w], wm[w]);
            for (int i = 1; i < W; i++) inword[pos + i] = 1;
            pos += W + int'($urandom_range(2, 0));
        end
        for (int i = 0; i < pos; i++) if (inword[i] && $urandom_range(3, 0) == 0) d_st[i] = 1'b1;
        run_sched(pos + 2);
        for (int w = 0; w < nw; w++) begin
            int es, esn;
            bit ec, ev, ecn, evn;
            logic [3:0] g, gn;
            int j;
            j = starts[w];
            ref_word(W, int'(wa[w]), int'(wb[w]), wm[w], es, ec, ev);
            ref_word(W, int'(wa[w]), int'(wb[w]), 1'b0, esn, ecn, evn);
            for (int i = 0; i < W; i++) begin g[i] = o_s[j + i]; gn[i] = n_s[j + i]; end
            if (int'(g) != es || o_dn[j+W-1] !== 1'b1 || o_co[j+W-1] !== ec || o_ov[j+W-1] !== ev) begin
                errs++;
                if (errs <= 4) $display("FAIL rand_w%0d got=%b c%b v%b want=%0d c%b v%b", w, g, o_co[j+W-1], o_ov[j+W-1], es, ec, ev);
            end
            if (int'(gn) != esn || n_co[j+W-1] !== ecn || n_ov[j+W-1] !== evn) begin
                errn++;
                if (errn <= 4) $display("FAIL rand_n%0d got=%b c%b v%b want=%0d c%b v%b", w, gn, n_co[j+W-1], n_ov[j+W-1], esn, ecn, evn);
            end
        end
        nv = 0; nd = 0;
        for (int i = 0; i < pos + 2; i++) begin
            if (o_sv[i] === 1'b1) nv++;
            if (o_dn[i] === 1'b1) nd++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL rand_words got=%0d wrong want=0", errs); end
        total++;
        if (errn != 0) begin bad++; $display("FAIL rand_suben0 got=%0d wrong want=0", errn); end
        total++;
        if (nv != nw * W || nd != nw) begin
            bad++; $display("FAIL rand_counts got=valid%0d done%0d want=valid%0d done%0d", nv, nd, nw * W, nw);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_width1();
        test_sub_en0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
